// File: rtl/pp_pkg.sv
// Shared constants, state encoding and width helper for the ping-pong buffer
// write-side arbiter and its round-robin picker.
package pp_pkg;

    localparam int PP_N_SRC     = 4;
    localparam int PP_DATA_W    = 64;
    localparam int PP_MAX_BEATS = 64;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in parameter expressions; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pp_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// to the lowest requester when nothing at or above ptr is requesting.
module rr_pick
    import pp_pkg::*;
#(
    parameter int N_SRC = PP_N_SRC,
    parameter int ID_W  = clog2(PP_N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [N_SRC-1:0] upper_req;
    logic [ID_W-1:0]  upper_idx;
    logic [ID_W-1:0]  lower_idx;

    always_comb begin
        upper_req = '0;
        for (int i = 0; i < N_SRC; i++) begin
            upper_req[i] = req[i] && (ID_W'(i) >= ptr);
        end
    end

    // Scan downwards so the lowest set bit is the one left standing.
    always_comb begin
        upper_idx = '0;
        lower_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                upper_idx = ID_W'(i);
            end
            if (req[i]) begin
                lower_idx = ID_W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = (|upper_req) ? upper_idx : lower_idx;

endmodule

// File: rtl/pp_src_arbiter.sv
// Packet-granular round-robin merge of N_SRC upstream beat streams into the
// single write port of the ping-pong RAM buffer controller.
//
// Handshake: a beat moves on a rising edge where o_data_en and i_buf_ready are
// both high; src_ready mirrors i_buf_ready onto the granted source only, and
// o_data/o_tlast read as zero whenever o_data_en is low.
module pp_src_arbiter
    import pp_pkg::*;
#(
    parameter int N_SRC     = PP_N_SRC,
    parameter int DATA_W    = PP_DATA_W,
    parameter int MAX_BEATS = PP_MAX_BEATS,
    parameter int ID_W      = clog2(PP_N_SRC)
) (
    input  logic                    clk_50m,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        cfg_src_mask,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_last,
    output logic [N_SRC-1:0]        src_ready,
    input  logic                    i_buf_ready,
    output logic                    o_data_en,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_tlast,
    output logic [ID_W-1:0]         o_grant_id,
    output logic                    o_busy,
    output logic                    o_seg_cut
);

    localparam int               CNT_W     = (clog2(MAX_BEATS) < 1) ? 1 : clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]  LAST_SRC  = ID_W'(N_SRC - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             seg_cut_q, seg_cut_d;

    logic [N_SRC-1:0]  req;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              max_beat;
    logic              xfer;

    assign req = src_valid & cfg_src_mask;

    rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = src_valid[i];
                g_last  = src_last[i];
                g_data  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        seg_cut_d  = 1'b0;
        src_ready  = '0;
        o_data_en  = 1'b0;
        o_data     = '0;
        o_tlast    = 1'b0;
        xfer       = 1'b0;
        max_beat   = (beat_cnt_q == LAST_BEAT);

        case (state_q)
            ARB: begin
                // The mask is only consulted here, so a change mid-burst waits for the next pick.
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BURST;
                end
            end

            BURST: begin
                o_data_en = g_valid;
                o_data    = g_valid ? g_data : '0;
                o_tlast   = g_valid & (g_last | max_beat);
                for (int i = 0; i < N_SRC; i++) begin
                    src_ready[i] = (grant_q == ID_W'(i)) & i_buf_ready;
                end
                xfer = g_valid & i_buf_ready;

                if (xfer) begin
                    if (o_tlast) begin
                        state_d    = ARB;
                        rr_ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + ID_W'(1);
                        beat_cnt_d = '0;
                        // A cut that coincides with the real packet end is not a cut.
                        seg_cut_d  = ~g_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q    <= ARB;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            seg_cut_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            seg_cut_q  <= seg_cut_d;
        end
    end

    assign o_grant_id = grant_q;
    assign o_busy     = (state_q == BURST);
    assign o_seg_cut  = seg_cut_q;

    a_ready_onehot0: assert property (@(posedge clk_50m) disable iff (!rst_n)
        $onehot0(src_ready));

    a_idle_zero: assert property (@(posedge clk_50m) disable iff (!rst_n)
        !o_data_en |-> (o_data == '0 && !o_tlast));

    a_cut_after_tlast: assert property (@(posedge clk_50m) disable iff (!rst_n)
        o_seg_cut |-> $past(o_tlast & i_buf_ready));

endmodule

// File: tb/tb_pp_src_arbiter.sv
// Directed bench for pp_src_arbiter: per-source beat memories drive the inputs,
// an expected-beat queue scores every transfer, per-test cycle counts check timing.
module tb_pp_src_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int W  = 67;

    // ---------------- clock / reset ----------------
    logic clk_50m = 1'b0;
    logic rst_n;
    always #10 clk_50m = ~clk_50m;

    logic [NS-1:0]    cfg_src_mask;
    logic [NS-1:0]    src_valid;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_last;
    logic [NS-1:0]    src_ready;
    logic             i_buf_ready;
    logic             o_data_en;
    logic [DW-1:0]    o_data;
    logic             o_tlast;
    logic [1:0]       o_grant_id;
    logic             o_busy;
    logic             o_seg_cut;

    pp_src_arbiter dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .cfg_src_mask (cfg_src_mask),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .i_buf_ready  (i_buf_ready),
        .o_data_en    (o_data_en),
        .o_data       (o_data),
        .o_tlast      (o_tlast),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_seg_cut    (o_seg_cut)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int xfer_cnt;
    int cut_cnt;
    int cut_at;

    logic [NS-1:0] snap_ready;
    logic          snap_en;
    logic          snap_tlast;
    logic          snap_busy;
    logic          snap_cut;
    logic [1:0]    snap_gid;
    logic [DW-1:0] snap_data;

    // ---------------- source model ----------------
    logic [DW:0]   src_mem [NS][128];
    int            src_wr  [NS];
    int            src_rd  [NS];
    logic [NS-1:0] src_hold;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int s, input int p, input int b);
        return {8'hC0, 8'(s), 16'(p), 32'(b)};
    endfunction

    task automatic push_pkt(input int s, input int p, input int len);
        for (int b = 0; b < len; b++) begin
            src_mem[s][src_wr[s]] = {(b == len - 1), mk(s, p, b)};
            src_wr[s]++;
        end
    endtask

    task automatic exp_beat(input int gid, input logic last, input logic [DW-1:0] data);
        exp_q.push_back({2'(gid), last, data});
    endtask

    task automatic exp_pkt(input int s, input int p, input int len);
        for (int b = 0; b < len; b++) begin
            exp_beat(s, (b == len - 1), mk(s, p, b));
        end
    endtask

    // Idle sources present junk data and a high last flag, which the DUT must hide.
    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (src_rd[i] < src_wr[i] && !src_hold[i]) begin
                src_valid[i]          = 1'b1;
                src_last[i]           = src_mem[i][src_rd[i]][DW];
                src_data[i*DW +: DW]  = src_mem[i][src_rd[i]][DW-1:0];
            end else begin
                src_valid[i]          = 1'b0;
                src_last[i]           = 1'b1;
                src_data[i*DW +: DW]  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            end
        end
    endtask

    // One cycle: sample at negedge, score, then update sources just after posedge.
    task automatic tick();
        logic [NS-1:0] pop;
        logic [W-1:0]  e;
        logic [NS-1:0] want_ready;
        @(negedge clk_50m);
        snap_ready = src_ready;
        snap_en    = o_data_en;
        snap_tlast = o_tlast;
        snap_busy  = o_busy;
        snap_cut   = o_seg_cut;
        snap_gid   = o_grant_id;
        snap_data  = o_data;
        pop = '0;
        if (rst_n) begin
            if (o_data_en && i_buf_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", W'(exp_q.size()), W'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {o_grant_id, o_tlast, o_data}, e);
                    want_ready = 4'b0001 << e[W-1:W-2];
                    check("src_ready", W'(src_ready), W'(want_ready));
                end
            end else if (!o_data_en) begin
                check("idle_zero", W'({o_tlast, o_data}), W'(0));
            end
            if (o_seg_cut) begin
                cut_cnt++;
                cut_at = cyc + 1;
            end
            pop = src_ready & src_valid;
        end
        @(posedge clk_50m);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (pop[i]) src_rd[i]++;
        end
        drive_inputs();
        cyc++;
    endtask

    task automatic start_test();
        cyc      = 0;
        xfer_cnt = 0;
        cut_cnt  = 0;
        cut_at   = -1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        cfg_src_mask = 4'b1111;
        i_buf_ready  = 1'b1;
        src_hold     = '0;
        for (int i = 0; i < NS; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        exp_q.delete();
        drive_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, W'(exp_q.size()), W'(0));
    endtask

    task automatic wait_xfers(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_reach"}, W'(xfer_cnt), W'(target));
    endtask

    task automatic check_reset_snap(input string tag);
        check({tag, "_ready"}, W'(snap_ready), W'(0));
        check({tag, "_en"},    W'(snap_en),    W'(0));
        check({tag, "_data"},  W'(snap_data),  W'(0));
        check({tag, "_tlast"}, W'(snap_tlast), W'(0));
        check({tag, "_gid"},   W'(snap_gid),   W'(0));
        check({tag, "_busy"},  W'(snap_busy),  W'(0));
        check({tag, "_cut"},   W'(snap_cut),   W'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        apply_reset();
        start_test();
        tick();
        check_reset_snap("rst");

        // 1: single 4-beat packet from src0
        apply_reset();
        push_pkt(0, 0, 4);
        exp_pkt(0, 0, 4);
        drive_inputs();
        start_test();
        tick();
        check("t1_arb_en",   W'(snap_en),   W'(0));
        check("t1_arb_busy", W'(snap_busy), W'(0));
        run_drain("t1", 50);
        check("t1_cycles", W'(cyc), W'(5));
        tick();
        check("t1_end_busy", W'(snap_busy), W'(0));
        check("t1_end_gid",  W'(snap_gid),  W'(0));
        check("t1_cuts",     W'(cut_cnt),   W'(0));

        // 2: three sources, two 3-beat packets each, strict rotation
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 3; s++) begin
                push_pkt(s, p, 3);
                exp_pkt(s, p, 3);
            end
        end
        drive_inputs();
        start_test();
        run_drain("t2", 100);
        check("t2_cycles", W'(cyc),     W'(24));
        check("t2_cuts",   W'(cut_cnt), W'(0));

        // 3: 70-beat packet on src1 is cut at 64; src3 slips in between
        apply_reset();
        push_pkt(1, 0, 70);
        push_pkt(3, 0, 2);
        for (int b = 0; b < 64; b++) exp_beat(1, (b == 63), mk(1, 0, b));
        exp_pkt(3, 0, 2);
        for (int b = 64; b < 70; b++) exp_beat(1, (b == 69), mk(1, 0, b));
        drive_inputs();
        start_test();
        run_drain("t3", 200);
        check("t3_cycles", W'(cyc),     W'(75));
        check("t3_cuts",   W'(cut_cnt), W'(1));
        check("t3_cut_at", W'(cut_at),  W'(66));

        // 4: back-pressure at beat 10, then a 2-cycle source gap at beat 15
        apply_reset();
        push_pkt(0, 0, 20);
        push_pkt(2, 0, 1);
        exp_pkt(0, 0, 20);
        exp_pkt(2, 0, 1);
        drive_inputs();
        start_test();
        wait_xfers("t4a", 10, 40);
        i_buf_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_stall_ready", W'(snap_ready), W'(0));
            check("t4_stall_data",  W'({snap_en, snap_data}), W'({1'b1, mk(0, 0, 10)}));
        end
        i_buf_ready = 1'b1;
        wait_xfers("t4b", 15, 30);
        src_hold[0] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t4_gap_busy", W'({snap_busy, snap_en, snap_gid}), W'({1'b1, 1'b0, 2'd0}));
        end
        src_hold[0] = 1'b0;
        drive_inputs();
        run_drain("t4", 50);
        check("t4_cycles", W'(cyc), W'(30));

        // 5: src1 masked off until a mask change in the middle of src0's second packet
        apply_reset();
        cfg_src_mask = 4'b1101;
        push_pkt(0, 0, 3);
        push_pkt(0, 1, 3);
        push_pkt(1, 0, 2);
        exp_pkt(0, 0, 3);
        exp_pkt(0, 1, 3);
        exp_pkt(1, 0, 2);
        drive_inputs();
        start_test();
        wait_xfers("t5a", 4, 20);
        cfg_src_mask = 4'b1111;
        run_drain("t5", 50);
        check("t5_cycles", W'(cyc), W'(11));

        // 6: reset in the middle of a src2 burst, rr_ptr must return to 0
        apply_reset();
        push_pkt(1, 0, 1);
        push_pkt(2, 0, 30);
        exp_pkt(1, 0, 1);
        for (int b = 0; b < 20; b++) exp_beat(2, 1'b0, mk(2, 0, b));
        drive_inputs();
        start_test();
        wait_xfers("t6a", 21, 60);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push_pkt(1, 1, 1);
        exp_pkt(1, 1, 1);
        for (int b = 20; b < 30; b++) exp_beat(2, (b == 29), mk(2, 0, b));
        drive_inputs();
        start_test();
        tick();
        check_reset_snap("t6_rst");
        run_drain("t6", 50);
        check("t6_cycles", W'(cyc), W'(13));

        // 7: packet end on beat 64 is not a cut; pointer wraps 3 -> 0
        apply_reset();
        push_pkt(3, 0, 64);
        push_pkt(3, 1, 1);
        exp_pkt(3, 0, 64);
        drive_inputs();
        start_test();
        wait_xfers("t7a", 5, 20);
        push_pkt(0, 0, 1);
        exp_pkt(0, 0, 1);
        exp_pkt(3, 1, 1);
        drive_inputs();
        run_drain("t7", 150);
        check("t7_cycles", W'(cyc),     W'(69));
        check("t7_cuts",   W'(cut_cnt), W'(0));

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
